// File: rtl/dpram_reader_pkg.sv
// Shared types and constants for the dual-port RAM sequential reader.
package dpram_reader_pkg;

    // Reader job state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Skid FIFO depth; also the cap on words buffered plus in flight
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO between the RAM read pipeline and the output stream.
// The head register only changes on a pop or on a push into an empty FIFO,
// so the stream data stays stable while the consumer stalls.
module skid_fifo2
    import dpram_reader_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [data_width-1:0] head,
    output logic [1:0]            count
);

    logic [data_width-1:0] r_head;
    logic [data_width-1:0] r_tail;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    // A pop needs a word present; a push into a full FIFO only lands if a pop frees a slot
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);

    // Storage and occupancy update; flush empties the FIFO without touching data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end else begin
                        r_head <= push_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= push_data;
                    end else begin
                        r_tail <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule

// File: rtl/dpram_reader.sv
// Sequential reader for one port of the generic dual-port RAM.
// Walks the RAM from a start address for a given word count, absorbs the
// RAM's one-cycle read latency and streams the words on valid/ready.
// Optional feature macro: DPRAM_READER_ABORT_EN adds an abort input that
// cancels a running job and discards buffered/in-flight data.
//
// state    | meaning
// ST_IDLE  | waiting for start; done may pulse here
// ST_READ  | issuing reads while FIFO + inflight has room
// ST_DRAIN | all reads issued; waiting for the last word to leave
module dpram_reader
    import dpram_reader_pkg::*;
#(
    parameter int address_width = 10,
    parameter int data_width    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [address_width-1:0] start_address,
    input  logic [address_width:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [address_width-1:0] ram_address,
    input  logic [data_width-1:0]    ram_q,
    output logic [data_width-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef DPRAM_READER_ABORT_EN
   ,input  logic                     abort
`endif
);

    localparam logic [address_width-1:0] ADDR_ONE = {{(address_width-1){1'b0}}, 1'b1};
    localparam logic [address_width:0]   REM_ONE  = {{address_width{1'b0}}, 1'b1};

    state_t                   r_state;
    logic [address_width-1:0] r_addr;
    logic [address_width:0]   r_remaining;
    logic                     r_inflight;
    logic                     r_done;

    logic [1:0]               w_count;
    logic [data_width-1:0]    w_head;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_abort;
    logic                     w_issue;
    logic                     w_last_xfer;
    logic [2:0]               w_occ;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && out_ready;

    // Occupancy after this cycle's pop; pop never exceeds what is buffered
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

`ifdef DPRAM_READER_ABORT_EN
    assign w_abort = abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_issue     = (r_state == ST_READ) && !w_abort && (w_occ < 3'(FIFO_DEPTH));
    assign w_last_xfer = w_pop && (w_count == 2'd1) && !r_inflight;

    // Job FSM, address/remaining counters and the one-deep read-latency tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= start_address;
                            r_remaining <= length;
                            r_state     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_ONE;
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_xfer) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_abort) begin
                r_state <= ST_IDLE;
            end
        end
    end

    skid_fifo2 #(.data_width(data_width)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_abort),
        .push      (r_inflight),
        .push_data (ram_q),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign ram_address = r_addr;
    assign out_data    = w_head;
    assign out_valid   = w_valid;

endmodule

// File: tb/tb_dpram_reader.sv
// Self-checking bench for dpram_reader with an attached RAM model and a
// word-queue reference of each job.
module tb_dpram_reader;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [AW:0]   length = '0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
`ifdef DPRAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic [DW-1:0] mem [N];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_address];

    dpram_reader #(.address_width(AW), .data_width(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_address (start_address),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .ram_address   (ram_address),
        .ram_q         (ram_q),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
`ifdef DPRAM_READER_ABORT_EN
       ,.abort         (abort)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready always high, 1 random ready, 2 stall 5 cycles after 3rd transfer
    // intr_kind: 0 none, 1 reset, 2 abort (applied when intr_at words have transferred)
    task automatic run_job(input int sa, input int len, input int mode, input int intr_kind,
                           input int intr_at, input bit busy_start, input bit immediate,
                           input bit chain);
        logic [DW-1:0] expq[$];
        int got = 0;
        int cyc = 0;
        int stall = 0;
        int issued;
        bit prev_stalled = 1'b0;
        logic [DW-1:0] prev_data = '0;
        for (int i = 0; i < len; i++) expq.push_back(mem[(sa + i) % N]);
        if (!immediate) @(negedge clk);
        start = 1'b1;
        start_address = AW'(sa);
        length = (AW+1)'(len);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (got < len && cyc < len * 8 + 20) begin
            if (prev_stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            check("done_low", done, 0);
            check("busy_high", busy, 1);
            if (len < N) begin
                issued = (int'(ram_address) - sa + N) % N;
                check("inflight_le2", (issued - got) <= 2, 1);
            end
            if (mode == 0) begin
                if (cyc < len) check("ram_address_seq", ram_address, (sa + cyc) % N);
                check("valid_latency", out_valid, cyc >= 2);
            end
            if (busy_start && cyc == 2) begin
                start = 1'b1;
                start_address = 10'h100;
                length = 11'd5;
            end else begin
                start = 1'b0;
            end
            if (intr_kind != 0 && got == intr_at) begin
                out_ready = 1'b0;
                start = 1'b0;
                if (intr_kind == 1) reset = 1'b1;
`ifdef DPRAM_READER_ABORT_EN
                if (intr_kind == 2) abort = 1'b1;
`endif
                @(negedge clk);
                reset = 1'b0;
`ifdef DPRAM_READER_ABORT_EN
                abort = 1'b0;
`endif
                check("intr_busy", busy, 0);
                check("intr_valid", out_valid, 0);
                check("intr_done", done, 0);
                if (intr_kind == 1) begin
                    check("rst_data", out_data, 0);
                    check("rst_addr", ram_address, 0);
                end
                @(negedge clk);
                check("intr_no_done", done, 0);
                check("intr_valid2", out_valid, 0);
                return;
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (got == 3 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                check("stall_data", out_data, expq[got]);
            end else out_ready = 1'b1;
            if (out_valid && out_ready) begin
                check("data", out_data, expq[got]);
                got++;
            end
            prev_stalled = out_valid && !out_ready;
            prev_data = out_data;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("words_received", got, len);
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        check("valid_after", out_valid, 0);
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = DW'(i & 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_addr", ram_address, 0);
        reset = 1'b0;

        // wrap across the top of the address space
        run_job(10'h3FE, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        // back-pressure: stall after 3rd transfer
        run_job(10'h010, 16, 2, 0, 0, 1'b0, 1'b0, 1'b0);

        // zero-length job
        @(negedge clk);
        start = 1'b1;
        start_address = 10'h155;
        length = '0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", out_valid, 0);
        @(negedge clk);
        check("zero_done_end", done, 0);
        check("zero_busy_end", busy, 0);
        check("zero_valid_end", out_valid, 0);

        // start while busy is ignored
        run_job(10'h020, 12, 1, 0, 0, 1'b1, 1'b0, 1'b0);
        // reset mid-job, then a normal job
        run_job(10'h040, 8, 0, 1, 3, 1'b0, 1'b0, 1'b0);
        run_job(10'h050, 8, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        // new start accepted in the done cycle
        run_job(10'h060, 5, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_job(10'h070, 3, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        // full-RAM read
        run_job(10'h123, N, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // random contents and jobs
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 40)), 1, 0, 0,
                    1'b0, 1'b0, 1'b0);
        end

`ifdef DPRAM_READER_ABORT_EN
        run_job(10'h200, 10, 0, 2, 2, 1'b0, 1'b0, 1'b0);
        run_job(10'h210, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
